hello_world: RTL and testbench

- Self-running HD44780-compatible 16x2 character LCD driver, 8-bit parallel bus, write-only (RW tied low externally).
- After reset: waits for LCD power-up, sends fixed init command sequence, writes "Hello World!" on line 1, then idles forever.
- Top-level leaf block driven by an 8 MHz board clock; no host interface.

---
 rtl/hello_world.sv | 170 +++++++++++++++++
 tb/tb_hello_world.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hello_world.sv
// Self-running HD44780 16x2 LCD driver: power-up wait, init commands, then "Hello World!".
// Define HELLO_WORLD_LINE2_EN to also write "LCD 16x2" on the second line.
module hello_world #(
  parameter int unsigned POWERUP_CYCLES    = 160000,
  parameter int unsigned SETUP_CYCLES      = 1,
  parameter int unsigned E_PULSE_CYCLES    = 4,
  parameter int unsigned CMD_WAIT_CYCLES   = 400,
  parameter int unsigned CLEAR_WAIT_CYCLES = 16000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic       lcd_rs_o,
  output logic       lcd_e_o,
  output logic [7:0] lcd_data_o
);

  function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_CYCLES = maxOf(maxOf(maxOf(POWERUP_CYCLES, SETUP_CYCLES),
                                             maxOf(E_PULSE_CYCLES, CMD_WAIT_CYCLES)),
                                             CLEAR_WAIT_CYCLES);
  localparam int unsigned CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

`ifdef HELLO_WORLD_LINE2_EN
  localparam int unsigned ROM_LEN = 26;
`else
  localparam int unsigned ROM_LEN = 17;
`endif

  localparam logic [4:0]       IDX_LAST     = 5'(ROM_LEN - 1);
  localparam logic [CNT_W-1:0] POWERUP_LAST = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(E_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMD_LAST     = CNT_W'(CMD_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(CLEAR_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Each entry is {rs, data}; rs=1 marks character data.
  function automatic logic [8:0] romEntry(input logic [4:0] idx);
    logic [8:0] entry;
    entry = 9'h000;
    case (idx)
      5'd0:  entry = 9'h038;
      5'd1:  entry = 9'h00C;
      5'd2:  entry = 9'h001;
      5'd3:  entry = 9'h006;
      5'd4:  entry = 9'h080;
      5'd5:  entry = {1'b1, "H"};
      5'd6:  entry = {1'b1, "e"};
      5'd7:  entry = {1'b1, "l"};
      5'd8:  entry = {1'b1, "l"};
      5'd9:  entry = {1'b1, "o"};
      5'd10: entry = {1'b1, " "};
      5'd11: entry = {1'b1, "W"};
      5'd12: entry = {1'b1, "o"};
      5'd13: entry = {1'b1, "r"};
      5'd14: entry = {1'b1, "l"};
      5'd15: entry = {1'b1, "d"};
      5'd16: entry = {1'b1, "!"};
`ifdef HELLO_WORLD_LINE2_EN
      5'd17: entry = 9'h0C0;
      5'd18: entry = {1'b1, "L"};
      5'd19: entry = {1'b1, "C"};
      5'd20: entry = {1'b1, "D"};
      5'd21: entry = {1'b1, " "};
      5'd22: entry = {1'b1, "1"};
      5'd23: entry = {1'b1, "6"};
      5'd24: entry = {1'b1, "x"};
      5'd25: entry = {1'b1, "2"};
`endif
      default: entry = 9'h000;
    endcase
    return entry;
  endfunction

  state_e           state_q;
  logic [4:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rs_q;
  logic             e_q;
  logic [7:0]       data_q;

  logic [4:0]       idx_d;
  logic [8:0]       nextEntry_d;
  logic [CNT_W-1:0] waitLast_d;

  assign idx_d       = idx_q + 5'd1;
  assign nextEntry_d = romEntry(idx_d);
  // The byte still on the bus decides whether the long Clear Display wait applies.
  assign waitLast_d  = (!rs_q && data_q == 8'h01) ? CLEAR_LAST : CMD_LAST;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_POWERUP;
      idx_q   <= 5'd0;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      case (state_q)
        ST_POWERUP: begin
          if (cnt_q == POWERUP_LAST) begin
            cnt_q            <= '0;
            {rs_q, data_q}   <= romEntry(idx_q);
            state_q          <= ST_SETUP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_q   <= '0;
            e_q     <= 1'b1;
            state_q <= ST_PULSE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_PULSE: begin
          if (cnt_q == PULSE_LAST) begin
            cnt_q   <= '0;
            e_q     <= 1'b0;
            state_q <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q == waitLast_d) begin
            cnt_q <= '0;
            idx_q <= idx_d;
            if (idx_q == IDX_LAST) begin
              state_q <= ST_DONE;
            end else begin
              {rs_q, data_q} <= nextEntry_d;
              state_q        <= ST_SETUP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_POWERUP;
        end
      endcase
    end
  end

  assign lcd_rs_o   = rs_q;
  assign lcd_e_o    = e_q;
  assign lcd_data_o = data_q;

endmodule

// File: tb/tb_hello_world.sv
// Directed bench for hello_world with shortened timing parameters.
// Captures every E falling edge and checks bytes, pulse widths, gaps and reset behaviour.
module tb_hello_world;

  logic       clk;
  logic       rst_n;
  logic       lcdRs;
  logic       lcdE;
  logic [7:0] lcdData;

  int checks;
  int errors;
  int cycleCount;
  int stableErr;
  int highCnt;
  int relCycle;
  int lastRiseCount;
  int gapExp;
  logic       prevE;
  logic [8:0] prevBus;

  logic [8:0] bytes[$];
  int         riseCycle[$];
  int         fallCycle[$];
  int         highTimes[$];
  logic [8:0] expBytes[$];

  hello_world #(
    .POWERUP_CYCLES   (20),
    .SETUP_CYCLES     (1),
    .E_PULSE_CYCLES   (4),
    .CMD_WAIT_CYCLES  (8),
    .CLEAR_WAIT_CYCLES(30)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .lcd_rs_o  (lcdRs),
    .lcd_e_o   (lcdE),
    .lcd_data_o(lcdData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bus monitor: records E edges, high times and bus stability around each pulse.
  always @(negedge clk) begin
    cycleCount++;
    if (!rst_n) begin
      prevE   = 1'b0;
      prevBus = 9'h000;
      highCnt = 0;
    end else begin
      if (lcdE && !prevE) begin
        riseCycle.push_back(cycleCount);
        highCnt = 1;
        if ({lcdRs, lcdData} !== prevBus) stableErr++;
      end else if (lcdE) begin
        highCnt++;
        if ({lcdRs, lcdData} !== prevBus) stableErr++;
      end else if (prevE) begin
        highTimes.push_back(highCnt);
        bytes.push_back({lcdRs, lcdData});
        fallCycle.push_back(cycleCount);
        if ({lcdRs, lcdData} !== prevBus) stableErr++;
      end
      prevE   = lcdE;
      prevBus = {lcdRs, lcdData};
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rstVal);
    @(negedge clk);
    #2;
    rst_n = rstVal;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitBytes(input int n, input int budget);
    int k;
    k = 0;
    while (bytes.size() < n && k < budget) begin
      tick();
      k++;
    end
    checkOutput("wait_bytes_timeout", 32'(bytes.size() >= n), 32'd1);
  endtask

  task automatic waitEHigh(input int budget);
    int k;
    k = 0;
    while (lcdE !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    checkOutput("wait_e_timeout", 32'(lcdE === 1'b1), 32'd1);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    cycleCount = 0;
    stableErr  = 0;
    highCnt    = 0;
    prevE      = 1'b0;
    prevBus    = 9'h000;
    rst_n      = 1'b0;

    expBytes = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080,
                 9'h148, 9'h165, 9'h16C, 9'h16C, 9'h16F, 9'h120,
                 9'h157, 9'h16F, 9'h172, 9'h16C, 9'h164, 9'h121};
`ifdef HELLO_WORLD_LINE2_EN
    expBytes.push_back(9'h0C0);
    expBytes.push_back(9'h14C);
    expBytes.push_back(9'h143);
    expBytes.push_back(9'h144);
    expBytes.push_back(9'h120);
    expBytes.push_back(9'h131);
    expBytes.push_back(9'h136);
    expBytes.push_back(9'h178);
    expBytes.push_back(9'h132);
`endif

    $display("[TB] reset phase");
    repeat (5) tick();
    checkOutput("reset_rs", 32'(lcdRs), 32'd0);
    checkOutput("reset_e", 32'(lcdE), 32'd0);
    checkOutput("reset_data", 32'(lcdData), 32'h00);

    applyStimulus(1'b1);
    relCycle = cycleCount;
    repeat (20) tick();
    checkOutput("no_pulse_powerup", 32'(riseCycle.size()), 32'd0);

    waitBytes(1, 200);
    checkOutput("first_rise_latency", 32'(riseCycle[0] - relCycle), 32'd21);
    checkOutput("first_byte", 32'(bytes[0]), 32'h038);

    // Interrupt the sequence while the 'W' byte is being strobed.
    waitBytes(11, 1000);
    waitEHigh(100);
    checkOutput("pre_reset_bus", 32'({lcdE, lcdRs, lcdData}), 32'h357);
    applyStimulus(1'b0);
    #1;
    checkOutput("async_reset_bus", 32'({lcdE, lcdRs, lcdData}), 32'h000);

    repeat (3) tick();
    bytes.delete();
    riseCycle.delete();
    fallCycle.delete();
    highTimes.delete();
    stableErr = 0;
    applyStimulus(1'b1);
    relCycle = cycleCount;

    $display("[TB] full sequence after restart");
    waitBytes(expBytes.size(), 3000);
    checkOutput("byte_count", 32'(bytes.size()), 32'(expBytes.size()));
    checkOutput("restart_latency", 32'(riseCycle[0] - relCycle), 32'd21);
    for (int i = 0; i < expBytes.size(); i++) begin
      checkOutput($sformatf("byte_%0d", i), 32'(bytes[i]), 32'(expBytes[i]));
      checkOutput($sformatf("e_high_%0d", i), 32'(highTimes[i]), 32'd4);
    end
    for (int i = 0; i + 1 < expBytes.size(); i++) begin
      gapExp = (expBytes[i] == 9'h001) ? 36 : 14;
      checkOutput($sformatf("gap_%0d", i), 32'(fallCycle[i+1] - fallCycle[i]), 32'(gapExp));
    end
    checkOutput("bus_stable", 32'(stableErr), 32'd0);

    $display("[TB] idle phase");
    lastRiseCount = riseCycle.size();
    repeat (2000) tick();
    checkOutput("no_extra_pulses", 32'(riseCycle.size()), 32'(lastRiseCount));
    checkOutput("done_bus_hold", 32'({lcdE, lcdRs, lcdData}), 32'({1'b0, expBytes[expBytes.size()-1]}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
